// File: rtl/led_pattern_decoder_if.sv
// Bundle of the pattern-step inputs and decoded-mode outputs of led_pattern_decoder.
// The master side supplies steps; the slave side is the decoder itself.
interface led_pattern_decoder_if;
    logic       ena;
    logic       sample;
    logic [7:0] led_in;
    logic [1:0] mode_out;
    logic       mode_valid;
    logic       step_err;
    logic [7:0] err_count;

    modport master (
        output ena, sample, led_in,
        input  mode_out, mode_valid, step_err, err_count
    );

    modport slave (
        input  ena, sample, led_in,
        output mode_out, mode_valid, step_err, err_count
    );
endinterface

// File: rtl/led_pattern_decoder.sv
// Classifies a stream of 8-bit LED pattern steps as COUNT, SCAN, LFSR or ALT and locks onto it.
// Optional saturating mismatch counter on err_count is enabled by LED_PATTERN_DECODER_ERRCNT_EN.
module led_pattern_decoder #(
    parameter int LOCK_THRESH = 4,
    parameter int MISS_LIMIT  = 2
) (
    input logic                  clk,
    input logic                  reset,
    led_pattern_decoder_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [1:0] M_COUNT = 2'd0;
    localparam logic [1:0] M_SCAN  = 2'd1;
    localparam logic [1:0] M_LFSR  = 2'd2;
    localparam logic [1:0] M_ALT   = 2'd3;

    logic [1:0]      state;
    logic [7:0]      prev;
    logic [3:0][2:0] score;
    logic [3:0][2:0] next_score;
    logic [3:0]      match;
    logic [3:0]      hit;
    logic [1:0]      miss;
    logic [1:0]      miss_inc;
    logic [1:0]      winner;
    logic [1:0]      mode_r;
    logic            valid_r;
    logic            err_r;
    logic            accept;
    logic            lfsr_fb;
    logic            scan_onehot;
    logic [7:0]      cur;

    assign accept      = bus.ena & bus.sample;
    assign cur         = bus.led_in;
    assign lfsr_fb     = prev[7] ^ prev[5] ^ prev[4] ^ prev[3];
    assign scan_onehot = $onehot(prev[6:0]) && !prev[7];
    assign miss_inc    = miss + 2'd1;

    // All four step rules are evaluated against the same (prev, cur) pair.
    always_comb begin
        match = '0;
        match[M_COUNT] = (cur == prev + 8'd1);
        if (prev == 8'h00 || prev == 8'h80) begin
            match[M_SCAN] = (cur == 8'h01);
        end else if (scan_onehot) begin
            match[M_SCAN] = (cur == {prev[6:0], 1'b0});
        end
        match[M_LFSR] = (cur == {prev[6:0], lfsr_fb}) || (prev == 8'h00 && cur == 8'h01);
        match[M_ALT]  = (prev == 8'h55) ? (cur == 8'hAA) : (cur == 8'h55);
    end

    always_comb begin
        next_score = '0;
        hit        = '0;
        for (int m = 0; m < 4; m++) begin
            if (match[m]) begin
                next_score[m] = (score[m] == 3'd7) ? 3'd7 : score[m] + 3'd1;
            end
            hit[m] = (next_score[m] >= 3'(LOCK_THRESH));
        end
    end

    // Tie-break order ALT > SCAN > LFSR > COUNT.
    always_comb begin
        winner = M_COUNT;
        if (hit[M_ALT]) begin
            winner = M_ALT;
        end else if (hit[M_SCAN]) begin
            winner = M_SCAN;
        end else if (hit[M_LFSR]) begin
            winner = M_LFSR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            prev    <= 8'h00;
            score   <= '0;
            miss    <= 2'd0;
            mode_r  <= M_COUNT;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            err_r <= 1'b0;
            if (accept) begin
                prev <= cur;
                case (state)
                    IDLE: begin
                        state <= TRACK;
                    end
                    TRACK: begin
                        score <= next_score;
                        if (|hit) begin
                            state   <= LOCKED;
                            mode_r  <= winner;
                            valid_r <= 1'b1;
                            miss    <= 2'd0;
                        end
                    end
                    LOCKED: begin
                        score <= next_score;
                        if (match[mode_r]) begin
                            miss <= 2'd0;
                        end else begin
                            err_r <= 1'b1;
                            if (miss_inc == 2'(MISS_LIMIT)) begin
                                state   <= TRACK;
                                valid_r <= 1'b0;
                                miss    <= 2'd0;
                            end else begin
                                miss <= miss_inc;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.mode_out   = mode_r;
    assign bus.mode_valid = valid_r;
    assign bus.step_err   = err_r;

`ifdef LED_PATTERN_DECODER_ERRCNT_EN
    logic [7:0] err_cnt;

    // Counts at the same edge that raises step_err, so both move together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= 8'h00;
        end else if (accept && state == LOCKED && !match[mode_r] && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign bus.err_count = err_cnt;
`else
    assign bus.err_count = 8'h00;
`endif
endmodule

// File: tb/tb_led_pattern_decoder.sv
// Directed and randomized bench for led_pattern_decoder against a history-based reference model.
// Honors LED_PATTERN_DECODER_ERRCNT_EN for the expected err_count.
module tb_led_pattern_decoder;
    localparam int LT = 4;
    localparam int ML = 2;

    logic clk;
    logic reset;
    led_pattern_decoder_if bus ();

    led_pattern_decoder #(.LOCK_THRESH(LT), .MISS_LIMIT(ML)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted-step history plus lock bookkeeping.
    bit  has_prev;
    bit  locked;
    int  mode;
    int  miss;
    int  cnt;
    bit  exp_err;
    int  hist[$];

    function automatic bit model_match(int m, int p, int c);
        bit r;
        r = 0;
        case (m)
            0: r = (((p + 1) % 256) == c);
            1: begin
                if (p == 0 || p == 128) r = (c == 1);
                else for (int k = 0; k < 7; k++) if (p == (1 << k)) r = (c == p * 2);
            end
            2: r = (c == (((p * 2) % 256) + ($countones(p & 'hB8) % 2))) || (p == 0 && c == 1);
            default: r = (c == ((p == 85) ? 170 : 85));
        endcase
        return r;
    endfunction

    function automatic int gen_next(int m, int p);
        int n;
        case (m)
            0: n = (p + 1) % 256;
            1: begin
                n = 1;
                for (int k = 0; k < 7; k++) if (p == (1 << k)) n = p * 2;
            end
            2: n = ((p * 2) % 256) + ($countones(p & 'hB8) % 2);
            default: n = (p == 85) ? 170 : 85;
        endcase
        return n;
    endfunction

    function automatic int run_len(int m);
        int r;
        r = 0;
        for (int i = hist.size() - 1; i >= 1; i--) begin
            if (model_match(m, hist[i-1], hist[i])) r++;
            else break;
        end
        return (r > 7) ? 7 : r;
    endfunction

    task automatic model_reset();
        has_prev = 0;
        locked   = 0;
        mode     = 0;
        miss     = 0;
        cnt      = 0;
        exp_err  = 0;
        hist.delete();
    endtask

    task automatic model_edge(input bit e, input bit s, input int v);
        int order[4];
        exp_err = 0;
        if (!(e && s)) return;
        if (!has_prev) begin
            has_prev = 1;
            hist.delete();
            hist.push_back(v);
            return;
        end
        hist.push_back(v);
        if (hist.size() > 8) void'(hist.pop_front());
        if (!locked) begin
            order = '{3, 1, 2, 0};
            foreach (order[i]) begin
                if (!locked && run_len(order[i]) >= LT) begin
                    locked = 1;
                    mode   = order[i];
                    miss   = 0;
                end
            end
        end else if (model_match(mode, hist[hist.size()-2], v)) begin
            miss = 0;
        end else begin
            exp_err = 1;
            if (cnt < 255) cnt++;
            miss++;
            if (miss == ML) begin
                locked = 0;
                miss   = 0;
            end
        end
    endtask

    function automatic int exp_cnt();
`ifdef LED_PATTERN_DECODER_ERRCNT_EN
        return cnt;
`else
        return 0;
`endif
    endfunction

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        check_val({tag, ".mode_out"},   {6'd0, bus.mode_out}, 8'(locked || mode != 0 ? mode : 0));
        check_val({tag, ".mode_valid"}, {7'd0, bus.mode_valid}, {7'd0, locked});
        check_val({tag, ".step_err"},   {7'd0, bus.step_err}, {7'd0, exp_err});
        check_val({tag, ".err_count"},  bus.err_count, 8'(exp_cnt()));
    endtask

    task automatic apply_stimulus(input string tag, input bit e, input bit s, input int v);
        @(negedge clk);
        bus.ena    = e;
        bus.sample = s;
        bus.led_in = 8'(v);
        @(posedge clk);
        model_edge(e, s, v);
        #1;
        check_output(tag);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_val({tag, ".rst_mode"},  {6'd0, bus.mode_out}, 8'h00);
        check_val({tag, ".rst_valid"}, {7'd0, bus.mode_valid}, 8'h00);
        check_val({tag, ".rst_err"},   {7'd0, bus.step_err}, 8'h00);
        check_val({tag, ".rst_cnt"},   bus.err_count, 8'h00);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_steps(input string tag, input int vals[$]);
        foreach (vals[i]) apply_stimulus(tag, 1'b1, 1'b1, vals[i]);
    endtask

    initial begin
        int smode;
        int last;
        int v;
        bit e;
        bit s;
        reset      = 1'b1;
        bus.ena    = 1'b0;
        bus.sample = 1'b0;
        bus.led_in = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_output("reset_state");
        reset = 1'b0;

        run_steps("count", '{'h10, 'h11, 'h12, 'h13});
        check_val("count.no_lock_yet", {7'd0, bus.mode_valid}, 8'h00);
        apply_stimulus("count", 1'b1, 1'b1, 'h14);
        check_val("count.locked", {7'd0, bus.mode_valid}, 8'h01);
        check_val("count.mode",   {6'd0, bus.mode_out}, 8'h00);

        apply_stimulus("miss1", 1'b1, 1'b1, 'h20);
        check_val("miss1.err", {7'd0, bus.step_err}, 8'h01);
        apply_stimulus("miss2", 1'b1, 1'b1, 'h15);
        check_val("miss2.err",   {7'd0, bus.step_err}, 8'h01);
        check_val("miss2.valid", {7'd0, bus.mode_valid}, 8'h00);
`ifdef LED_PATTERN_DECODER_ERRCNT_EN
        check_val("miss2.cnt", bus.err_count, 8'h02);
`else
        check_val("miss2.cnt", bus.err_count, 8'h00);
`endif
        apply_stimulus("idle", 1'b1, 1'b0, 'h00);
        check_val("idle.err_cleared", {7'd0, bus.step_err}, 8'h00);

        pulse_reset("midreset");
        run_steps("alt", '{'h55, 'hAA, 'h55, 'hAA, 'h55});
        check_val("alt.valid", {7'd0, bus.mode_valid}, 8'h01);
        check_val("alt.mode",  {6'd0, bus.mode_out}, 8'h03);

        pulse_reset("rst2");
        run_steps("scan", '{'h01, 'h02, 'h04, 'h08, 'h10});
        check_val("scan.valid", {7'd0, bus.mode_valid}, 8'h01);
        check_val("scan.mode",  {6'd0, bus.mode_out}, 8'h01);

        pulse_reset("rst3");
        run_steps("ena", '{'h10, 'h11});
        apply_stimulus("ena_off", 1'b0, 1'b1, 'h12);
        apply_stimulus("ena_off", 1'b0, 1'b1, 'h13);
        run_steps("ena", '{'h12, 'h13});
        check_val("ena.no_lock", {7'd0, bus.mode_valid}, 8'h00);
        apply_stimulus("ena", 1'b1, 1'b1, 'h14);
        check_val("ena.lock", {7'd0, bus.mode_valid}, 8'h01);

        pulse_reset("rst4");
        smode = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) smode = $urandom_range(0, 3);
            last = (hist.size() > 0) ? hist[hist.size()-1] : 0;
            v = ($urandom_range(0, 9) < 8) ? gen_next(smode, last) : int'($urandom_range(0, 255));
            e = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 9) < 7);
            apply_stimulus("rand", e, s, v);
            if (i % 1000 == 999) pulse_reset("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_pattern_decoder.md
LED_PATTERN_DECODER -- requirements
Module: led_pattern_decoder

Interface
REQ-001 Parameter LOCK_THRESH, default 4, consecutive matching steps required to lock a mode (range 1..7).
REQ-002 Parameter MISS_LIMIT, default 2, consecutive mismatching steps while locked that force unlock (range 1..3).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ena  input  1  block enable; when low, all state SHALL hold.
REQ-006 sample  input  1  one-cycle strobe; led_in holds a new pattern step.
REQ-007 led_in  input  8  observed LED pattern value.
REQ-008 mode_out  output  2  detected mode: 00 COUNT, 01 SCAN, 10 LFSR, 11 ALT.
REQ-009 mode_valid  output  1  high while a mode is locked.
REQ-010 step_err  output  1  one-cycle pulse on a locked-mode mismatch.
REQ-011 err_count  output  8  saturating mismatch count (see Configuration).

Function
REQ-012 Accepted step = rising edge with ena=1 and sample=1; on each accepted step, led_in SHALL be stored as prev.
REQ-013 States: IDLE (no prev), TRACK (classifying), LOCKED; reset SHALL enter IDLE.
REQ-014 IDLE: first accepted step SHALL load prev only and move to TRACK; scores SHALL stay 0.
REQ-015 Step match rules, all evaluated in parallel on (prev, cur=led_in):
 - COUNT: cur == prev+1 mod 256 (FF->00 matches).
 - SCAN: cur==01 when prev is 00 or 80; cur==prev<<1 when prev is one-hot in 01..40.
 - LFSR: cur == {prev[6:0], prev[7]^prev[5]^prev[4]^prev[3]}; also prev==00 with cur==01.
 - ALT: cur==AA when prev==55; cur==55 when prev!=55.
REQ-016 Each mode SHALL keep a 3-bit score: +1 on match (saturating at 7), cleared to 0 on mismatch.
REQ-017 TRACK->LOCKED when any updated score >= LOCK_THRESH; ties resolved by priority ALT > SCAN > LFSR > COUNT.
REQ-018 LOCKED: a step matching the locked mode SHALL clear the miss counter; a mismatch SHALL pulse step_err and increment the miss counter.
REQ-019 On the miss counter reaching MISS_LIMIT, the block SHALL return to TRACK, deassert mode_valid, and clear the miss counter; scores continue updating from the current step.
REQ-020 Scores SHALL keep updating in LOCKED, so that relock after unlock takes effect at the same step as the REQ-017 condition.
REQ-021 All outputs SHALL be registered; mode_out/mode_valid/step_err SHALL reflect a step in the cycle after its accepting edge.
REQ-022 mode_out SHALL hold the last locked mode after unlock; it is meaningful only when mode_valid=1.
REQ-023 sample asserted with ena=0 SHALL be ignored entirely (no prev load, no score change).

Reset
REQ-024 reset SHALL asynchronously force: state IDLE, prev=00, all scores 0, miss counter 0, mode_out=00, mode_valid=0, step_err=0, err_count=00.
REQ-025 Reset asserted mid-sequence SHALL discard all history; first step after release SHALL be treated per REQ-014.

Configuration
REQ-026 Macro LED_PATTERN_DECODER_ERRCNT_EN defined: err_count SHALL increment on every step_err pulse, saturating at FF, cleared only by reset.
REQ-027 Macro undefined: err_count SHALL be constant 00 with no counter logic; all other behaviour unchanged.

Verification
REQ-028 Assert reset mid-operation -> immediately mode_valid=0, mode_out=00, step_err=0, err_count=00.
REQ-029 Steps 10,11,12,13,14 -> cycle after 5th accepting edge: mode_valid=1, mode_out=00.
REQ-030 Steps 55,AA,55,AA,55 -> mode_valid=1, mode_out=11 (LFSR score broken by 55->AA).
REQ-031 Steps 01,02,04,08,10 -> mode_valid=1, mode_out=01 (LFSR fails at 08->10, COUNT at 02->04).
REQ-032 Locked COUNT at 14, steps 20 then 15 -> step_err pulses twice; mode_valid=0 after 2nd; err_count=02 with macro, 00 without.
REQ-033 Steps 10..14 with ena=0 on 3rd and 4th sample strobes -> no lock until two further valid matching steps.
